// File: rtl/nor_sweep_checker_if.sv
// Signal bundle between the NOR sweep checker and its environment.
// The slave side is the checker. The master side drives start and returns dut_y.
interface nor_sweep_checker_if #(
  parameter int WIDTH = 1,
  parameter int ERRW  = 16
);
  logic             start;
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] b_out;
  logic [WIDTH-1:0] dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERRW-1:0]  err_count;
  logic             first_err_valid;
  logic [WIDTH-1:0] first_err_a;
  logic [WIDTH-1:0] first_err_b;

  modport master (
    output start, dut_y,
    input  a_out, b_out, busy, done, pass, err_count,
           first_err_valid, first_err_a, first_err_b
  );

  modport slave (
    input  start, dut_y,
    output a_out, b_out, busy, done, pass, err_count,
           first_err_valid, first_err_a, first_err_b
  );
endinterface

// File: rtl/nor_sweep_checker.sv
// Exhaustively sweeps every (a, b) operand pair through an external NOR unit.
// Each result is checked against ~(a|b), and the mismatch count and the first failing vector are recorded.
module nor_sweep_checker #(
  parameter int WIDTH  = 1,
  parameter int SETTLE = 1,
  parameter int ERRW   = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  nor_sweep_checker_if.slave bus
);
  localparam int VW = 2 * WIDTH;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [ERRW-1:0] ERR_MAX     = '1;

  logic [1:0]       state_q, state_d;
  logic [VW-1:0]    vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERRW-1:0]  err_q, err_d;
  logic             fev_q, fev_d;
  logic [WIDTH-1:0] fea_q, fea_d;
  logic [WIDTH-1:0] feb_q, feb_d;

  logic [WIDTH-1:0] a_w, b_w, expect_y;

  assign a_w      = vec_q[VW-1:WIDTH];
  assign b_w      = vec_q[WIDTH-1:0];
  assign expect_y = ~(a_w | b_w);

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    fev_d    = fev_q;
    fea_d    = fea_q;
    feb_d    = feb_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d  = S_APPLY;
          vec_d    = '0;
          settle_d = '0;
          err_d    = '0;
          fev_d    = 1'b0;
          fea_d    = '0;
          feb_d    = '0;
        end
      end
      S_APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = S_CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      S_CHECK: begin
        // dut_y is only trusted here, after the vector has settled
        if (bus.dut_y != expect_y) begin
          if (err_q != ERR_MAX) err_d = err_q + 1'b1;
          if (!fev_q) begin
            fev_d = 1'b1;
            fea_d = a_w;
            feb_d = b_w;
          end
        end
        if (&vec_q) begin
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VW'(1);
          state_d = S_APPLY;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      fev_q    <= 1'b0;
      fea_q    <= '0;
      feb_q    <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fev_q    <= fev_d;
      fea_q    <= fea_d;
      feb_q    <= feb_d;
    end
  end

  assign bus.a_out           = a_w;
  assign bus.b_out           = b_w;
  assign bus.busy            = (state_q == S_APPLY) || (state_q == S_CHECK);
  assign bus.done            = (state_q == S_DONE);
  assign bus.pass            = (err_q == '0);
  assign bus.err_count       = err_q;
  assign bus.first_err_valid = fev_q;
  assign bus.first_err_a     = fea_q;
  assign bus.first_err_b     = feb_q;
endmodule
